// File: rtl/mem_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_pkg
// Shared memory-bus definitions used by the arbiter, its requesters and the
// byte-serial memory controller: operation codes, access lengths and the
// all-zero data word.
// -----------------------------------------------------------------------------
package mem_req_arbiter_pkg;

    // Memory operation codes carried on *_op.
    localparam logic [1:0] MEM_NOP  = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [1:0] MEM_SAVE = 2'd2;

    // Access lengths carried on *_len.
    localparam logic [1:0] MEM_WORD = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_BYTE = 2'd2;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage : mem_req_arbiter_pkg

// File: rtl/mem_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_starve_ctr
// Saturating fairness counter for the memory arbiter. Counts LSU grants made
// while instruction fetch is waiting; cleared whenever fetch is granted.
//
// Ports
//   clk_in  : system clock, rising edge
//   rst_in  : synchronous active-high reset (count -> 0)
//   en      : advance enable; while low the count holds
//   inc     : add one, saturating at LIMIT
//   clr     : return to zero (wins over inc)
//   cnt     : current count
// -----------------------------------------------------------------------------
module mem_starve_ctr #(
    parameter  int LIMIT = 4,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LimitW = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every combinational output takes its hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != LimitW)) begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : mem_starve_ctr

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Two-requester arbiter in front of a single byte-serial memory controller.
// Instruction fetch (IF, always word loads) and the load/store unit (LSU)
// compete for one downstream port. LSU normally wins; a saturating fairness
// counter forces an IF grant after STARVE_LIMIT consecutive LSU grants made
// while IF was waiting. A taken jump (flush) cancels fetch traffic: it blocks
// an IF grant and discards any fetch response still in flight.
//
// Ports
//   clk_in, rst_in      : clock (rising edge), synchronous active-high reset
//   rdy_in              : pipeline advance; while low everything holds
//   flush               : jump taken, cancels IF traffic
//   if_req/if_addr      : IF request in;  if_rdy/if_out  : IF response out
//   lsu_op/len/addr/data: LSU request in; lsu_rdy/lsu_out: LSU response out
//   dn_op/len/addr/data : request to memory controller
//   dn_rdy/dn_out       : response from memory controller
// -----------------------------------------------------------------------------
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_out,

    input  logic [1:0]  lsu_op,
    input  logic [1:0]  lsu_len,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_data,
    output logic        lsu_rdy,
    output logic [31:0] lsu_out,

    output logic [1:0]  dn_op,
    output logic [1:0]  dn_len,
    output logic [31:0] dn_addr,
    output logic [31:0] dn_data,
    input  logic        dn_rdy,
    input  logic [31:0] dn_out
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_LSU,
        S_DRAIN
    } state_e;

    state_e      state_q,   state_d;
    logic [1:0]  dn_op_q,   dn_op_d;
    logic [1:0]  dn_len_q,  dn_len_d;
    logic [31:0] dn_addr_q, dn_addr_d;
    logic [31:0] dn_data_q, dn_data_d;
    logic [31:0] if_out_q,  if_out_d;
    logic [31:0] lsu_out_q, lsu_out_d;
    logic        if_rdy_q,  if_rdy_d;
    logic        lsu_rdy_q, lsu_rdy_d;

    logic [CNT_W-1:0] starve_cnt;
    logic             lsu_pending;
    logic             starve_hit;
    logic             if_grant;
    logic             lsu_grant;

    // Grant decision, only meaningful in IDLE while the pipeline advances.
    // A flush blocks the IF grant outright, so a forced-fairness cycle that
    // coincides with a flush falls back to serving a pending LSU request.
    always_comb begin
        lsu_pending = (lsu_op != MEM_NOP);
        starve_hit  = (starve_cnt == CNT_W'(STARVE_LIMIT));
        if_grant    = 1'b0;
        lsu_grant   = 1'b0;
        if (rdy_in && (state_q == S_IDLE)) begin
            if (if_req && !flush && (!lsu_pending || starve_hit)) begin
                if_grant = 1'b1;
            end else if (lsu_pending) begin
                lsu_grant = 1'b1;
            end
        end
    end

    mem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in),
        .inc    (lsu_grant && if_req),
        .clr    (if_grant),
        .cnt    (starve_cnt)
    );

    // Next-state and output logic. Everything holds by default so that a low
    // rdy_in freezes state, the downstream request and any rdy pulse alike.
    always_comb begin
        state_d   = state_q;
        dn_op_d   = dn_op_q;
        dn_len_d  = dn_len_q;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        if_out_d  = if_out_q;
        lsu_out_d = lsu_out_q;
        if_rdy_d  = if_rdy_q;
        lsu_rdy_d = lsu_rdy_q;

        if (rdy_in) begin
            if_rdy_d  = 1'b0;
            lsu_rdy_d = 1'b0;

            unique case (state_q)
                // dn_rdy is ignored here; a grant captures the request.
                S_IDLE: begin
                    if (if_grant) begin
                        state_d   = S_BUSY_IF;
                        dn_op_d   = MEM_LOAD;
                        dn_len_d  = MEM_WORD;
                        dn_addr_d = if_addr;
                        dn_data_d = ZeroWord;
                    end else if (lsu_grant) begin
                        state_d   = S_BUSY_LSU;
                        dn_op_d   = lsu_op;
                        dn_len_d  = lsu_len;
                        dn_addr_d = lsu_addr;
                        dn_data_d = lsu_data;
                    end
                end

                S_BUSY_IF: begin
                    if (dn_rdy) begin
                        // A flush in the response cycle still drops the data.
                        if (!flush) begin
                            if_rdy_d = 1'b1;
                            if_out_d = dn_out;
                        end
                        dn_op_d = MEM_NOP;
                        state_d = S_IDLE;
                    end else if (flush) begin
                        state_d = S_DRAIN;
                    end
                end

                S_BUSY_LSU: begin
                    if (dn_rdy) begin
                        lsu_rdy_d = 1'b1;
                        // The captured op tells load from store.
                        if (dn_op_q == MEM_LOAD) begin
                            lsu_out_d = dn_out;
                        end
                        dn_op_d = MEM_NOP;
                        state_d = S_IDLE;
                    end
                end

                // The controller cannot abort, so wait out the cancelled fetch.
                S_DRAIN: begin
                    if (dn_rdy) begin
                        dn_op_d = MEM_NOP;
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    dn_op_d = MEM_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            dn_op_q   <= MEM_NOP;
            dn_len_q  <= MEM_WORD;
            dn_addr_q <= ZeroWord;
            dn_data_q <= ZeroWord;
            if_out_q  <= ZeroWord;
            lsu_out_q <= ZeroWord;
            if_rdy_q  <= 1'b0;
            lsu_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dn_op_q   <= dn_op_d;
            dn_len_q  <= dn_len_d;
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
            if_out_q  <= if_out_d;
            lsu_out_q <= lsu_out_d;
            if_rdy_q  <= if_rdy_d;
            lsu_rdy_q <= lsu_rdy_d;
        end
    end

    assign dn_op   = dn_op_q;
    assign dn_len  = dn_len_q;
    assign dn_addr = dn_addr_q;
    assign dn_data = dn_data_q;
    assign if_out  = if_out_q;
    assign lsu_out = lsu_out_q;
    assign if_rdy  = if_rdy_q;
    assign lsu_rdy = lsu_rdy_q;

endmodule : mem_req_arbiter

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter. A transaction-level reference (one
// outstanding request, a starvation tally, the expected output registers) is
// advanced on every rising edge; a negedge process compares all outputs with
// it each cycle. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int STARVE = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_out;
    logic [1:0]  lsu_op, lsu_len;
    logic [31:0] lsu_addr, lsu_data;
    logic        lsu_rdy;
    logic [31:0] lsu_out;
    logic [1:0]  dn_op, dn_len;
    logic [31:0] dn_addr, dn_data;
    logic        dn_rdy;
    logic [31:0] dn_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    mem_req_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdy   (if_rdy),
        .if_out   (if_out),
        .lsu_op   (lsu_op),
        .lsu_len  (lsu_len),
        .lsu_addr (lsu_addr),
        .lsu_data (lsu_data),
        .lsu_rdy  (lsu_rdy),
        .lsu_out  (lsu_out),
        .dn_op    (dn_op),
        .dn_len   (dn_len),
        .dn_addr  (dn_addr),
        .dn_data  (dn_data),
        .dn_rdy   (dn_rdy),
        .dn_out   (dn_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit          m_busy, m_is_if, m_flushed;
    int          m_starve;
    logic [1:0]  e_op, e_len;
    logic [31:0] e_addr, e_data, e_if_out, e_lsu_out;
    logic        e_if_rdy, e_lsu_rdy;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_busy = 0; m_is_if = 0; m_flushed = 0; m_starve = 0;
            e_op = MEM_NOP; e_len = MEM_WORD; e_addr = 0; e_data = 0;
            e_if_out = 0; e_lsu_out = 0; e_if_rdy = 0; e_lsu_rdy = 0;
        end else if (rdy_in) begin
            e_if_rdy  = 0;
            e_lsu_rdy = 0;
            if (!m_busy) begin
                if (if_req && !flush && (lsu_op == MEM_NOP || m_starve == STARVE)) begin
                    m_busy = 1; m_is_if = 1; m_flushed = 0; m_starve = 0;
                    e_op = MEM_LOAD; e_len = MEM_WORD; e_addr = if_addr; e_data = 0;
                end else if (lsu_op != MEM_NOP) begin
                    m_busy = 1; m_is_if = 0; m_flushed = 0;
                    if (if_req && m_starve < STARVE) m_starve++;
                    e_op = lsu_op; e_len = lsu_len; e_addr = lsu_addr; e_data = lsu_data;
                end
            end else if (dn_rdy) begin
                if (m_is_if) begin
                    if (!m_flushed && !flush) begin
                        e_if_rdy = 1;
                        e_if_out = dn_out;
                    end
                end else begin
                    e_lsu_rdy = 1;
                    if (e_op == MEM_LOAD) e_lsu_out = dn_out;
                end
                e_op   = MEM_NOP;
                m_busy = 0;
            end else if (m_is_if && flush) begin
                m_flushed = 1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (checking) begin
            check("cyc_dn_op",   {30'd0, dn_op},   {30'd0, e_op});
            check("cyc_dn_len",  {30'd0, dn_len},  {30'd0, e_len});
            check("cyc_dn_addr", dn_addr, e_addr);
            check("cyc_dn_data", dn_data, e_data);
            check("cyc_if_rdy",  {31'd0, if_rdy},  {31'd0, e_if_rdy});
            check("cyc_if_out",  if_out,  e_if_out);
            check("cyc_lsu_rdy", {31'd0, lsu_rdy}, {31'd0, e_lsu_rdy});
            check("cyc_lsu_out", lsu_out, e_lsu_out);
            check("cyc_rdy_excl", {31'd0, if_rdy & lsu_rdy}, 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_in = 1; rdy_in = 1; flush = 0; dn_rdy = 0; dn_out = 0;
        if_req = 0; if_addr = 0;
        lsu_op = MEM_NOP; lsu_len = MEM_WORD; lsu_addr = 0; lsu_data = 0;

        tick();
        checking = 1'b1;
        check("rst_dn_op",   {30'd0, dn_op},  {30'd0, MEM_NOP});
        check("rst_dn_len",  {30'd0, dn_len}, {30'd0, MEM_WORD});
        check("rst_dn_addr", dn_addr, 32'h0);
        check("rst_rdys",    {30'd0, if_rdy, lsu_rdy}, 32'd0);
        tick();
        rst_in = 0;
        tick();

        // Lone LSU word load.
        lsu_op = MEM_LOAD; lsu_len = MEM_WORD; lsu_addr = 32'h1000;
        tick();
        check("ld_dn_op",   {30'd0, dn_op}, {30'd0, MEM_LOAD});
        check("ld_dn_addr", dn_addr, 32'h1000);
        tick(); tick();
        dn_rdy = 1; dn_out = 32'hDEADBEEF;
        tick();
        check("ld_lsu_rdy", {31'd0, lsu_rdy}, 32'd1);
        check("ld_lsu_out", lsu_out, 32'hDEADBEEF);
        check("ld_dn_nop",  {30'd0, dn_op}, {30'd0, MEM_NOP});
        dn_rdy = 0; lsu_op = MEM_NOP;
        tick();
        check("ld_pulse_end", {31'd0, lsu_rdy}, 32'd0);

        // IF and LSU store together: LSU first, IF on the next IDLE.
        if_req = 1; if_addr = 32'h400;
        lsu_op = MEM_SAVE; lsu_len = MEM_BYTE; lsu_addr = 32'h2000; lsu_data = 32'hA5;
        tick();
        check("both_lsu_first", {30'd0, dn_op}, {30'd0, MEM_SAVE});
        dn_rdy = 1; dn_out = 32'h1111_1111;
        tick();
        dn_rdy = 0;
        check("st_lsu_rdy", {31'd0, lsu_rdy}, 32'd1);
        check("st_lsu_out_kept", lsu_out, 32'hDEADBEEF);
        lsu_op = MEM_NOP;
        tick();
        check("if_after_lsu_addr", dn_addr, 32'h400);
        check("if_after_lsu_data", dn_data, 32'h0);
        dn_rdy = 1; dn_out = 32'hCAFEF00D;
        tick();
        dn_rdy = 0;
        check("if_rdy_pulse", {31'd0, if_rdy}, 32'd1);
        check("if_out_val",   if_out, 32'hCAFEF00D);
        if_req = 0;
        tick();

        // Starvation: IF held, LSU back-to-back -> L L L L I L.
        if_req = 1; if_addr = 32'h300; lsu_op = MEM_LOAD; lsu_len = MEM_WORD;
        for (int k = 0; k < 6; k++) begin
            lsu_addr = 32'h3000 + 32'(4 * k);
            tick();
            if (k == 4) check("starve_if_grant", dn_addr, 32'h300);
            else        check("starve_lsu_grant", dn_addr, 32'h3000 + 32'(4 * k));
            dn_rdy = 1; dn_out = 32'(k);
            tick();
            dn_rdy = 0;
        end
        if_req = 0; lsu_op = MEM_NOP;
        tick();

        // Flush two cycles after IF grant, response five cycles after.
        if_req = 1; if_addr = 32'h200;
        tick();
        check("drain_grant", dn_addr, 32'h200);
        tick();
        flush = 1;
        tick();
        flush = 0; if_req = 0;
        tick();
        check("drain_hold3", dn_addr, 32'h200);
        tick();
        check("drain_hold4", {30'd0, dn_op}, {30'd0, MEM_LOAD});
        dn_rdy = 1; dn_out = 32'h5555_AAAA;
        tick();
        dn_rdy = 0;
        check("drain_no_if_rdy", {31'd0, if_rdy}, 32'd0);
        check("drain_nop", {30'd0, dn_op}, {30'd0, MEM_NOP});
        tick();

        // Flush with dn_rdy in BUSY_IF; flush during BUSY_LSU.
        if_req = 1; if_addr = 32'h500;
        tick();
        flush = 1; dn_rdy = 1; dn_out = 32'h1234_5678;
        tick();
        check("flush_rdy_no_if", {31'd0, if_rdy}, 32'd0);
        flush = 0; dn_rdy = 0; if_req = 0;
        tick();
        lsu_op = MEM_LOAD; lsu_addr = 32'h600;
        tick();
        flush = 1;
        tick();
        dn_rdy = 1; dn_out = 32'h0BAD_F00D;
        tick();
        check("flush_lsu_rdy", {31'd0, lsu_rdy}, 32'd1);
        check("flush_lsu_out", lsu_out, 32'h0BAD_F00D);
        flush = 0; dn_rdy = 0; lsu_op = MEM_NOP;
        tick();

        // Pause mid BUSY_LSU, including during the rdy pulse.
        lsu_op = MEM_SAVE; lsu_len = MEM_HALF; lsu_addr = 32'h700; lsu_data = 32'h55;
        tick();
        rdy_in = 0; dn_rdy = 1; dn_out = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pause_dn_op",   {30'd0, dn_op}, {30'd0, MEM_SAVE});
            check("pause_dn_addr", dn_addr, 32'h700);
            check("pause_no_rdy",  {31'd0, lsu_rdy}, 32'd0);
        end
        rdy_in = 1;
        tick();
        check("pause_resume_rdy", {31'd0, lsu_rdy}, 32'd1);
        check("pause_store_out",  lsu_out, 32'h0BAD_F00D);
        rdy_in = 0;
        tick();
        check("pause_pulse_held", {31'd0, lsu_rdy}, 32'd1);
        rdy_in = 1; dn_rdy = 0; lsu_op = MEM_NOP;
        tick();
        check("pause_pulse_end", {31'd0, lsu_rdy}, 32'd0);

        // Reset mid-transaction beats rdy_in and flush.
        lsu_op = MEM_LOAD; lsu_len = MEM_WORD; lsu_addr = 32'h800;
        tick();
        rst_in = 1; rdy_in = 0; flush = 1; dn_rdy = 1; dn_out = 32'h99;
        tick();
        check("rst_mid_dn_op",   {30'd0, dn_op}, {30'd0, MEM_NOP});
        check("rst_mid_dn_addr", dn_addr, 32'h0);
        check("rst_mid_lsu_out", lsu_out, 32'h0);
        check("rst_mid_if_out",  if_out, 32'h0);
        rst_in = 0; rdy_in = 1; flush = 0; lsu_op = MEM_NOP;
        tick();
        check("rst_mid_no_rdy", {31'd0, lsu_rdy}, 32'd0);
        dn_rdy = 0;
        tick();
        tick();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_req_arbiter
